wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter PEND_W, default 2: width of each per-register pending-write counter; maximum in-flight writes per register = 2^PEND_W-1.
REQ-002 SHALL have port clk_in, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port rdy_in, input, 1: global enable; low = no state change.
REQ-005 SHALL have ports wb_rd_addr, wb_rd_val and wb_ins_type, inputs of 5, 32 and 7 bits: writeback triple from the MEM/WB stage.
REQ-006 SHALL have ports iss_valid, iss_rd_addr and iss_ready: inputs of 1 and 5 bits and an output of 1 bit; the issue-side reservation handshake.
REQ-007 SHALL have port flush, input, 1: pipeline flush that discards all reservations.
REQ-008 SHALL have ports rs1_addr and rs2_addr, inputs, 5 bits each: read addresses.
REQ-009 SHALL have ports rs1_val and rs2_val, outputs, 32 bits each: read data.
REQ-010 SHALL have ports rs1_busy and rs2_busy, outputs, 1 bit each: operand still pending.
REQ-011 SHALL have port wb_count, output, 32 bits: count of retired register writes.

Function
REQ-012 SHALL hold 31 architectural 32-bit registers x1..x31; x0 SHALL read 0 always and never be written or reserved.
REQ-013 SHALL treat a writeback as valid (wb_en) only when all three hold: rdy_in=1; wb_ins_type is one of 0110111, 0010111, 1101111, 1100111, 0000011, 0010011 or 0110011; wb_rd_addr != 0.
REQ-014 SHALL, on wb_en, write wb_rd_val to wb_rd_addr at the clock edge (one-cycle write latency).
REQ-015 SHALL provide combinational reads with write-through bypass: if wb_en and rsN_addr==wb_rd_addr!=0, rsN_val = wb_rd_val in the same cycle.
REQ-016 SHALL keep a PEND_W-bit pending counter per register; counter for x0 is constant 0.
REQ-017 SHALL accept an issue (iss_fire) when iss_valid=1, iss_ready=1 and rdy_in=1; iss_rd_addr=0 fires but reserves nothing.
REQ-018 SHALL drive iss_ready=0 only when the counter of iss_rd_addr (nonzero address) is saturated at 2^PEND_W-1 and no wb_en to that register occurs this cycle; otherwise iss_ready=1.
REQ-019 SHALL update counters per edge: +1 on iss_fire to a register; -1 on wb_en to it; unchanged when both target the same register in the same cycle.
REQ-020 SHALL never decrement a zero counter (writeback without reservation writes data, counter stays 0).
REQ-021 SHALL drive rsN_busy = 1 when rsN_addr != 0 and (counter - (wb_en hits rsN_addr ? 1 : 0)) != 0; an in-cycle retiring write therefore clears busy combinationally.
REQ-022 SHALL, on flush=1 with rdy_in=1, clear all counters at the edge; a same-cycle wb_en SHALL still write data; a same-cycle issue SHALL be ignored.
REQ-023 SHALL increment wb_count by 1 per wb_en, wrapping modulo 2^32.
REQ-024 SHALL hold all state (registers, counters, wb_count) when rdy_in=0, with reads and bypass-free busy flags still valid.

Reset
REQ-025 SHALL, while rst_in=0, asynchronously clear all registers, counters and wb_count to 0.
REQ-026 SHALL, during reset, present outputs rs1_val=rs2_val=0, rs1_busy=rs2_busy=0, iss_ready=1 and wb_count=0.
REQ-027 SHALL resume normal operation on the first rising edge after rst_in returns high; an issue or writeback in flight when reset asserts SHALL be lost.

Verification
REQ-028 SHALL be verified by a bench covering: wb x5=0xDEADBEEF, ins_type 0110011 -> next cycle rs1_addr=5 reads 0xDEADBEEF; wb_count=1.
REQ-029 SHALL be verified by a bench covering: same-cycle wb x7=0x12345678 with rs2_addr=7 -> rs2_val=0x12345678 combinationally.
REQ-030 SHALL be verified by a bench covering: wb x0=0xFFFFFFFF, or ins_type 0100011 (store) to x3 -> x0 and x3 read 0; wb_count unchanged.
REQ-031 SHALL be verified by a bench covering: three issues to x9 -> iss_ready=0 for x9; rs1_busy=1; a fourth iss_valid is stalled; one wb x9 -> counter 2, iss_ready=1.
REQ-032 SHALL be verified by a bench covering: a simultaneous issue and wb to x4 with counter=1 -> counter stays 1, rs busy stays 1; flush -> all busy 0.
REQ-033 SHALL be verified by a bench covering: rst_in low mid-operation with counters nonzero -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Writeback, issue-reservation and read-port bundle for wb_regfile.
// master drives the pipeline side; slave is the register file.
interface wb_regfile_if;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_val;
    logic [6:0]  wb_ins_type;
    logic        iss_valid;
    logic [4:0]  iss_rd_addr;
    logic        iss_ready;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] wb_count;

    modport master (
        output wb_rd_addr, wb_rd_val, wb_ins_type,
        output iss_valid, iss_rd_addr, flush,
        output rs1_addr, rs2_addr,
        input  iss_ready, rs1_val, rs2_val,
        input  rs1_busy, rs2_busy, wb_count
    );

    modport slave (
        input  wb_rd_addr, wb_rd_val, wb_ins_type,
        input  iss_valid, iss_rd_addr, flush,
        input  rs1_addr, rs2_addr,
        output iss_ready, rs1_val, rs2_val,
        output rs1_busy, rs2_busy, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// 31x32 register file with write-through bypass and per-register
// pending-write counters for issue-side scoreboarding.
module wb_regfile #(
    parameter int PEND_W = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    wb_regfile_if.slave  bus
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [31:0]       regs_q [32];
    logic [PEND_W-1:0] pend_q [32];
    logic [PEND_W-1:0] pend_d [32];
    logic [31:0]       cnt_q;
    logic [31:0]       cnt_d;

    logic type_ok;
    logic wb_en;
    logic iss_fire;
    logic iss_hit_wb;
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        type_ok = 1'b0;
        case (bus.wb_ins_type)
            7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0110011: type_ok = 1'b1;
            default:    type_ok = 1'b0;
        endcase
    end

    // Gating with rst_in keeps bypass and busy quiet while in reset.
    assign wb_en = rst_in & rdy_in & type_ok
                 & (bus.wb_rd_addr != 5'd0);

    assign iss_hit_wb = wb_en & (bus.wb_rd_addr == bus.iss_rd_addr);

    assign bus.iss_ready = !((bus.iss_rd_addr != 5'd0)
                           && (pend_q[bus.iss_rd_addr] == PEND_MAX)
                           && !iss_hit_wb);

    assign iss_fire = rst_in & rdy_in & bus.iss_valid & bus.iss_ready;

    assign rs1_hit = wb_en & (bus.rs1_addr == bus.wb_rd_addr);
    assign rs2_hit = wb_en & (bus.rs2_addr == bus.wb_rd_addr);

    always_comb begin
        bus.rs1_val = regs_q[bus.rs1_addr];
        bus.rs2_val = regs_q[bus.rs2_addr];
        if (rs1_hit) bus.rs1_val = bus.wb_rd_val;
        if (rs2_hit) bus.rs2_val = bus.wb_rd_val;
        if (bus.rs1_addr == 5'd0) bus.rs1_val = 32'd0;
        if (bus.rs2_addr == 5'd0) bus.rs2_val = 32'd0;
    end

    // A retiring write this cycle no longer counts as pending.
    assign bus.rs1_busy = (bus.rs1_addr != 5'd0)
        && (pend_q[bus.rs1_addr] > PEND_W'(rs1_hit));
    assign bus.rs2_busy = (bus.rs2_addr != 5'd0)
        && (pend_q[bus.rs2_addr] > PEND_W'(rs2_hit));

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            logic inc;
            logic dec;
            inc = iss_fire && (bus.iss_rd_addr == 5'(i));
            dec = wb_en && (bus.wb_rd_addr == 5'(i));
            pend_d[i] = pend_q[i];
            if (i == 0) begin
                pend_d[i] = '0;
            end else if (rdy_in && bus.flush) begin
                pend_d[i] = '0;
            end else if (inc && !dec) begin
                pend_d[i] = pend_q[i] + 1'b1;
            end else if (dec && !inc && (pend_q[i] != '0)) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end
    end

    assign cnt_d        = wb_en ? cnt_q + 32'd1 : cnt_q;
    assign bus.wb_count = cnt_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= pend_d[i];
            end
            if (wb_en) begin
                regs_q[bus.wb_rd_addr] <= bus.wb_rd_val;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule
